approx_err_monitor: RTL

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

---
 rtl/approx_pkg.sv | 26 ++
 rtl/abs_diff9.sv | 31 +++
 rtl/approx_err_monitor.sv | 119 +++++++++++
 3 files changed

// File: rtl/approx_pkg.sv
// Shared types and widths for the approximate-adder error monitor.
// Optional signed bias accumulation is enabled by the ERR_BIAS_EN macro.
package approx_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int OP_W     = 8;
   localparam int SUM_W    = 9;
   localparam int ED_W     = 9;
   localparam int DIFF_W   = 10;
   localparam int CNT_W    = 16;
   localparam int SUM_ED_W = 25;
   localparam int BIAS_W   = 26;

   function automatic logic [BIAS_W-1:0] sext_diff(
      input logic [DIFF_W-1:0] d
   );
      return {{(BIAS_W-DIFF_W){d[DIFF_W-1]}}, d};
   endfunction

endpackage

// File: rtl/abs_diff9.sv
// Exact 9-bit sum of two operands and its distance from an approximate sum.
// With ERR_BIAS_EN the signed difference (approx - exact) is also produced.
module abs_diff9
   import approx_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   input  logic [SUM_W-1:0]  s,
`ifdef ERR_BIAS_EN
   output logic [DIFF_W-1:0] diff,
`endif
   output logic [ED_W-1:0]   ed
);

   logic [SUM_W-1:0] exact;

   always_comb begin
      exact = {1'b0, a} + {1'b0, b};
      if (exact >= s)
         ed = exact - s;
      else
         ed = s - exact;
   end

`ifdef ERR_BIAS_EN
   always_comb begin
      diff = {1'b0, s} - {1'b0, exact};
   end
`endif

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics for an approximate 8-bit adder.
// ERR_BIAS_EN adds a signed bias_sum output accumulating (s_apx - exact).
module approx_err_monitor
   import approx_pkg::*;
#(
   parameter int N_SAMPLES = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_W-1:0]     op_a,
   input  logic [OP_W-1:0]     op_b,
   input  logic [SUM_W-1:0]    s_apx,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    err_count,
   output logic [ED_W-1:0]     max_ed,
`ifdef ERR_BIAS_EN
   output logic [BIAS_W-1:0]   bias_sum,
`endif
   output logic [SUM_ED_W-1:0] sum_ed
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pend;
   logic [ED_W-1:0]  ed;
   logic [ED_W-1:0]  ed_q;
   logic             accept;

`ifdef ERR_BIAS_EN
   logic [DIFF_W-1:0] diff;
   logic [DIFF_W-1:0] diff_q;
`endif

   abs_diff9 u_diff (
      .a    (op_a),
      .b    (op_b),
      .s    (s_apx),
`ifdef ERR_BIAS_EN
      .diff (diff),
`endif
      .ed   (ed)
   );

   assign accept = in_valid & in_ready;

   // One pipeline stage: a sample accepted on edge k is accumulated on edge k+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         ed_q      <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_count <= '0;
         max_ed    <= '0;
         sum_ed    <= '0;
`ifdef ERR_BIAS_EN
         diff_q    <= '0;
         bias_sum  <= '0;
`endif
      end else begin
         pend <= 1'b0;
         if (pend) begin
            err_count <= err_count + CNT_W'(ed_q != '0);
            sum_ed    <= sum_ed + SUM_ED_W'(ed_q);
            if (ed_q > max_ed)
               max_ed <= ed_q;
`ifdef ERR_BIAS_EN
            bias_sum <= bias_sum + sext_diff(diff_q);
`endif
         end
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_RUN;
                  in_ready  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  cnt       <= '0;
                  err_count <= '0;
                  max_ed    <= '0;
                  sum_ed    <= '0;
`ifdef ERR_BIAS_EN
                  bias_sum  <= '0;
`endif
               end
            end
            S_RUN: begin
               if (accept) begin
                  pend <= 1'b1;
                  ed_q <= ed;
`ifdef ERR_BIAS_EN
                  diff_q <= diff;
`endif
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state    <= S_DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         endcase
      end
   end

endmodule
